mig7_ui_responder: RTL and testbench

- Synthesizable emulator of the MIG7 user-interface (UI) side: it responds to a UI initiator exactly as the DDR3 controller's app_* port does.
- Holds a small on-chip word memory and models the calibration delay, app_rdy backpressure, periodic refresh, and ZQ and self-refresh requests.
- Replaces the DDR3 controller in simulation and in no-DDR builds, so that traffic generators and stubs can be exercised against a deterministic responder.

---
 rtl/mig7_ui_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mig7_ui_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig7_ui_responder.sv
// mig7_ui_responder: deterministic stand-in for the MIG7 DDR3 controller user interface.
//
// Ports:
//   clk, rst                       UI clock and synchronous active-high reset
//   app_addr/app_cmd/app_en        command channel (cmd 000 write, 001 read, others no-op)
//   app_rdy                        command ready (only while idle in the ready state)
//   app_wdf_*                      write-data channel into a small FIFO; app_wdf_rdy = ready
//   app_rd_data*                   read data, valid exactly RD_LATENCY cycles after acceptance
//   app_ref/zq/sr_req, *_ack       maintenance requests and one-cycle acknowledges
//   app_sr_active                  self-refresh active
//   init_calib_complete            rises CALIB_CYCLES cycles after reset release
//   proto_err                      sticky protocol-violation flag
//
// The word memory is not reset, so its contents survive rst.
`timescale 1ns/1ps
module mig7_ui_responder #(
    parameter int unsigned DWIDTH         = 128,
    parameter int unsigned MWIDTH         = DWIDTH / 8,
    parameter int unsigned AWIDTH         = 28,
    parameter int unsigned MEM_AW         = 8,
    parameter int unsigned CALIB_CYCLES   = 64,
    parameter int unsigned RD_LATENCY     = 4,
    parameter int unsigned REFRESH_PERIOD = 256,
    parameter int unsigned REFRESH_BUSY   = 8,
    parameter int unsigned WDF_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] app_addr,
    input  logic [2:0]        app_cmd,
    input  logic              app_en,
    output logic              app_rdy,
    input  logic [DWIDTH-1:0] app_wdf_data,
    input  logic [MWIDTH-1:0] app_wdf_mask,
    input  logic              app_wdf_wren,
    input  logic              app_wdf_end,
    output logic              app_wdf_rdy,
    output logic [DWIDTH-1:0] app_rd_data,
    output logic              app_rd_data_valid,
    output logic              app_rd_data_end,
    input  logic              app_ref_req,
    input  logic              app_zq_req,
    input  logic              app_sr_req,
    output logic              app_ref_ack,
    output logic              app_zq_ack,
    output logic              app_sr_active,
    output logic              init_calib_complete,
    output logic              proto_err
);

    localparam int unsigned MemDepth = 1 << MEM_AW;
    localparam int unsigned WdfAw    = $clog2(WDF_DEPTH);
    localparam int unsigned CalibW   = $clog2(CALIB_CYCLES + 1);
    localparam int unsigned RefW     = $clog2(REFRESH_PERIOD + 1);
    localparam int unsigned BusyW    = $clog2(REFRESH_BUSY + 1);

    typedef enum logic [2:0] {StCalib, StReady, StWaitWdf, StBusy, StSelfRef} state_e;
    typedef enum logic [1:0] {BusyAuto, BusyRef, BusyZq} busy_e;

    state_e              state_q;
    busy_e               busy_kind_q;
    logic [CalibW-1:0]   calib_cnt_q;
    logic [RefW-1:0]     ref_timer_q;
    logic [BusyW-1:0]    busy_cnt_q;
    logic                auto_pend_q, ref_pend_q, zq_pend_q;
    logic [MEM_AW-1:0]   wait_idx_q;

    logic [DWIDTH-1:0]   mem [MemDepth];

    logic [DWIDTH-1:0]   wdf_data_q [WDF_DEPTH];
    logic [MWIDTH-1:0]   wdf_mask_q [WDF_DEPTH];
    logic [WdfAw:0]      wdf_wr_ptr_q, wdf_rd_ptr_q;
    logic                wdf_empty, wdf_full, wdf_push, wdf_pop, wdf_direct;

    logic [DWIDTH-1:0]   rd_pipe_data_q [RD_LATENCY];
    logic [RD_LATENCY-1:0] rd_pipe_vld_q;

    logic [MEM_AW-1:0]   cmd_idx;
    logic                cmd_accept, wr_accept, rd_accept;
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_widx;
    logic [DWIDTH-1:0]   mem_wdata;
    logic [MWIDTH-1:0]   mem_wmask;
    logic                zq_want, ref_want;
    logic                unused_addr;

    // One UI word spans 8 address units; upper bits alias.
    assign cmd_idx     = app_addr[MEM_AW+2:3];
    assign unused_addr = ^{app_addr[AWIDTH-1:MEM_AW+3], app_addr[2:0]};

    assign app_rdy         = (state_q == StReady);
    assign app_wdf_rdy     = init_calib_complete & ~wdf_full;
    assign app_rd_data_end = app_rd_data_valid;

    assign cmd_accept = app_en & app_rdy;
    assign wr_accept  = cmd_accept & (app_cmd == 3'b000);
    assign rd_accept  = cmd_accept & (app_cmd == 3'b001);

    assign wdf_empty = (wdf_wr_ptr_q == wdf_rd_ptr_q);
    assign wdf_full  = (wdf_wr_ptr_q[WdfAw] != wdf_rd_ptr_q[WdfAw]) &&
                       (wdf_wr_ptr_q[WdfAw-1:0] == wdf_rd_ptr_q[WdfAw-1:0]);
    // A beat that completes a waiting write bypasses the FIFO.
    assign wdf_push  = app_wdf_wren & app_wdf_rdy & ~wdf_direct;

    assign zq_want  = app_zq_req | zq_pend_q;
    assign ref_want = app_ref_req | ref_pend_q;

    always_comb begin
        wdf_pop    = 1'b0;
        wdf_direct = 1'b0;
        mem_we     = 1'b0;
        mem_widx   = cmd_idx;
        mem_wdata  = wdf_data_q[wdf_rd_ptr_q[WdfAw-1:0]];
        mem_wmask  = wdf_mask_q[wdf_rd_ptr_q[WdfAw-1:0]];
        if (wr_accept && !wdf_empty) begin
            wdf_pop = 1'b1;
            mem_we  = 1'b1;
        end else if (state_q == StWaitWdf) begin
            mem_widx = wait_idx_q;
            if (!wdf_empty) begin
                wdf_pop = 1'b1;
                mem_we  = 1'b1;
            end else if (app_wdf_wren) begin
                wdf_direct = 1'b1;
                mem_we     = 1'b1;
                mem_wdata  = app_wdf_data;
                mem_wmask  = app_wdf_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(MWIDTH); b++) begin
                if (!mem_wmask[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wdf_push) begin
            wdf_data_q[wdf_wr_ptr_q[WdfAw-1:0]] <= app_wdf_data;
            wdf_mask_q[wdf_wr_ptr_q[WdfAw-1:0]] <= app_wdf_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdf_wr_ptr_q <= '0;
            wdf_rd_ptr_q <= '0;
        end else begin
            if (wdf_push) wdf_wr_ptr_q <= wdf_wr_ptr_q + 1'b1;
            if (wdf_pop)  wdf_rd_ptr_q <= wdf_rd_ptr_q + 1'b1;
        end
    end

    // Read pipeline: stage 0 captures the word on the acceptance edge, output register
    // follows the last stage, giving exactly RD_LATENCY cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe_vld_q     <= '0;
            app_rd_data_valid <= 1'b0;
            app_rd_data       <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) rd_pipe_data_q[i] <= '0;
        end else begin
            rd_pipe_vld_q[0] <= rd_accept;
            if (rd_accept) rd_pipe_data_q[0] <= mem[cmd_idx];
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                rd_pipe_vld_q[i]  <= rd_pipe_vld_q[i-1];
                rd_pipe_data_q[i] <= rd_pipe_data_q[i-1];
            end
            app_rd_data_valid <= rd_pipe_vld_q[RD_LATENCY-1];
            if (rd_pipe_vld_q[RD_LATENCY-1]) app_rd_data <= rd_pipe_data_q[RD_LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= StCalib;
            busy_kind_q         <= BusyAuto;
            calib_cnt_q         <= '0;
            ref_timer_q         <= '0;
            busy_cnt_q          <= '0;
            auto_pend_q         <= 1'b0;
            ref_pend_q          <= 1'b0;
            zq_pend_q           <= 1'b0;
            wait_idx_q          <= '0;
            init_calib_complete <= 1'b0;
            app_ref_ack         <= 1'b0;
            app_zq_ack          <= 1'b0;
            app_sr_active       <= 1'b0;
            proto_err           <= 1'b0;
        end else begin
            app_ref_ack <= 1'b0;
            app_zq_ack  <= 1'b0;
            if ((app_wdf_end != app_wdf_wren) || (app_en && state_q == StCalib) ||
                (app_wdf_wren && wdf_full)) begin
                proto_err <= 1'b1;
            end

            unique case (state_q)
                StCalib: begin
                    if (calib_cnt_q == CalibW'(CALIB_CYCLES - 1)) begin
                        init_calib_complete <= 1'b1;
                        state_q             <= StReady;
                    end else begin
                        calib_cnt_q <= calib_cnt_q + 1'b1;
                    end
                end
                StReady: begin
                    // Latch pulsed requests so a lower-priority one is not lost.
                    if (app_ref_req) ref_pend_q <= 1'b1;
                    if (app_zq_req)  zq_pend_q  <= 1'b1;
                    busy_cnt_q <= '0;
                    if (wr_accept && wdf_empty) begin
                        wait_idx_q <= cmd_idx;
                        state_q    <= StWaitWdf;
                    end else if (app_sr_req) begin
                        state_q <= StSelfRef;
                    end else if (zq_want) begin
                        zq_pend_q   <= 1'b0;
                        busy_kind_q <= BusyZq;
                        state_q     <= StBusy;
                    end else if (ref_want) begin
                        ref_pend_q  <= 1'b0;
                        busy_kind_q <= BusyRef;
                        state_q     <= StBusy;
                    end else if (auto_pend_q) begin
                        auto_pend_q <= 1'b0;
                        busy_kind_q <= BusyAuto;
                        state_q     <= StBusy;
                    end
                end
                StWaitWdf: begin
                    if (wdf_pop || wdf_direct) state_q <= StReady;
                end
                StBusy: begin
                    if (busy_cnt_q == BusyW'(REFRESH_BUSY - 1)) begin
                        state_q     <= StReady;
                        app_ref_ack <= (busy_kind_q == BusyRef);
                        app_zq_ack  <= (busy_kind_q == BusyZq);
                    end else begin
                        busy_cnt_q <= busy_cnt_q + 1'b1;
                    end
                end
                StSelfRef: begin
                    app_sr_active <= app_sr_req;
                    if (!app_sr_req) state_q <= StReady;
                end
                default: state_q <= StCalib;
            endcase

            // Placed after the case so an expiry coinciding with consumption is kept.
            if (state_q != StCalib) begin
                if (ref_timer_q == RefW'(REFRESH_PERIOD - 1)) begin
                    ref_timer_q <= '0;
                    auto_pend_q <= 1'b1;
                end else begin
                    ref_timer_q <= ref_timer_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mig7_ui_responder.sv
`timescale 1ns/1ps
module tb_mig7_ui_responder;

    localparam int unsigned DW  = 128;
    localparam int unsigned MW  = 16;
    localparam int unsigned AW  = 28;
    localparam int          RDL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en, app_rdy;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid, app_rd_data_end;
    logic          app_ref_req, app_zq_req, app_sr_req;
    logic          app_ref_ack, app_zq_ack, app_sr_active;
    logic          init_calib_complete, proto_err;

    always #5 clk = ~clk;

    mig7_ui_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .app_ref_req         (app_ref_req),
        .app_zq_req          (app_zq_req),
        .app_sr_req          (app_sr_req),
        .app_ref_ack         (app_ref_ack),
        .app_zq_ack          (app_zq_ack),
        .app_sr_active       (app_sr_active),
        .init_calib_complete (init_calib_complete),
        .proto_err           (proto_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            acc;
    } rd_exp_t;

    rd_exp_t sb[$];
    rd_exp_t mon_e;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        logic [DW-1:0] exp;
        bit            cmd_first;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read-data monitor: pops the scoreboard on every valid beat.
    always @(negedge clk) begin
        if (!rst && (app_rd_data_valid || app_rd_data_end)) begin
            check("rd_data_end", app_rd_data_end, app_rd_data_valid);
            if (app_rd_data_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got valid beat expected none");
                end else begin
                    mon_e = sb.pop_front();
                    check("rd_data", app_rd_data, mon_e.data);
                    check("rd_latency", cyc - mon_e.acc, RDL);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic do_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr, output int acc);
        bit got = 1'b0;
        app_cmd  = cmd;
        app_addr = addr;
        app_en   = 1'b1;
        for (int n = 0; n < 300 && !got; n++) begin
            got = app_rdy;
            @(negedge clk);
        end
        app_en = 1'b0;
        acc    = cyc;
        check("cmd_accept", got, 1);
    endtask

    task automatic push_beat(input logic [DW-1:0] data, input logic [MW-1:0] mask);
        bit got = 1'b0;
        app_wdf_data = data;
        app_wdf_mask = mask;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        for (int n = 0; n < 300 && !got; n++) begin
            got = app_wdf_rdy;
            @(negedge clk);
        end
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        check("wdf_accept", got, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [MW-1:0] mask, input bit cmd_first);
        int acc;
        if (cmd_first) begin
            do_cmd(3'b000, addr, acc);
            push_beat(data, mask);
        end else begin
            push_beat(data, mask);
            do_cmd(3'b000, addr, acc);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        int acc;
        do_cmd(3'b001, addr, acc);
        sb.push_back('{data: exp, acc: acc});
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
        check("sb_drain", sb.size(), 0);
    endtask

    task automatic wait_calib();
        for (int n = 0; n < 200 && !init_calib_complete; n++) @(negedge clk);
        check("calib_done", init_calib_complete, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        wait_calib();
    endtask

    task automatic check_all_zero(input string name);
        check(name, {app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, app_ref_ack,
                     app_zq_ack, app_sr_active, init_calib_complete, proto_err}, 0);
        check({name, "_rd_data"}, app_rd_data, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, zq_at, ref_at, start, prev;
        int falls[$];
        int lens[$];
        logic [DW-1:0] bd;

        vecs[0] = '{addr: 28'h40,  data: {16{8'hA5}}, mask: 16'h0000,
                    exp: {16{8'hA5}}, cmd_first: 1'b0};
        vecs[1] = '{addr: 28'h48,  data: 128'h00112233_44556677_8899AABB_CCDDEEFF,
                    mask: 16'h0000, exp: 128'h00112233_44556677_8899AABB_CCDDEEFF,
                    cmd_first: 1'b1};
        vecs[2] = '{addr: 28'h845, data: {16{8'h3C}}, mask: 16'hFFFE,
                    exp: {{15{8'hA5}}, 8'h3C}, cmd_first: 1'b0};
        vecs[3] = '{addr: 28'h50,  data: {16{8'h11}}, mask: 16'h0000,
                    exp: {16{8'h11}}, cmd_first: 1'b0};
        vecs[4] = '{addr: 28'h50,  data: {16{8'hEE}}, mask: 16'hFFFF,
                    exp: {16{8'h11}}, cmd_first: 1'b1};
        vecs[5] = '{addr: 28'h50,  data: {16{8'h22}}, mask: 16'h00FF,
                    exp: {{8{8'h22}}, {8{8'h11}}}, cmd_first: 1'b0};
        vecs[6] = '{addr: 28'h7F8, data: 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98,
                    mask: 16'h0000, exp: 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98,
                    cmd_first: 1'b0};

        rst          = 1'b1;
        app_addr     = '0;
        app_cmd      = 3'b000;
        app_en       = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        app_ref_req  = 1'b0;
        app_zq_req   = 1'b0;
        app_sr_req   = 1'b0;

        // Reset state and calibration delay.
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            check("calib_rise", init_calib_complete, k == 64);
            if (k == 63) begin
                check("calib_rdy_low", app_rdy, 0);
                check("calib_wdf_rdy_low", app_wdf_rdy, 0);
            end
        end
        check("ready_after_calib", app_rdy, 1);
        check("wdf_rdy_after_calib", app_wdf_rdy, 1);

        // Table of write/read-back vectors.
        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].cmd_first);
            do_read(vecs[i].addr, vecs[i].exp);
        end
        drain();

        // Back-to-back reads return back-to-back in order.
        do_read(28'h40, {{15{8'hA5}}, 8'h3C});
        do_read(28'h48, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        do_read(28'h50, {{8{8'h22}}, {8{8'h11}}});
        drain();

        // Command before data: app_rdy low until the beat arrives 3 cycles later.
        do_write(28'h60, {16{8'h77}}, 16'h0000, 1'b0);
        do_cmd(3'b000, 28'h60, acc);
        for (int k = 0; k < 3; k++) begin
            check("wait_wdf_rdy_low", app_rdy, 0);
            if (k < 2) @(negedge clk);
        end
        app_wdf_data = {16{8'h99}};
        app_wdf_mask = 16'h0001;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        @(negedge clk);
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        check("wait_wdf_rdy_back", app_rdy, 1);
        do_read(28'h60, {{15{8'h99}}, 8'h77});
        drain();

        // Four beats ahead of any command fill the FIFO; a fifth is a protocol error.
        for (int i = 0; i < 4; i++) begin
            bd = {32{4'(i + 1)}};
            push_beat(bd, 16'h0000);
        end
        check("wdf_full_rdy", app_wdf_rdy, 0);
        check("proto_err_clean", proto_err, 0);
        app_wdf_data = {32{4'hF}};
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        @(negedge clk);
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        check("proto_err_overflow", proto_err, 1);
        for (int i = 0; i < 4; i++) do_cmd(3'b000, 28'hA0 + 28'(8 * i), acc);
        for (int i = 0; i < 4; i++) begin
            bd = {32{4'(i + 1)}};
            do_read(28'hA0 + 28'(8 * i), bd);
        end
        drain();

        // One-cycle reset mid-run clears every output.
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_reset");
        rst = 1'b0;
        sb.delete();
        wait_calib();

        // Refresh request: 8 busy cycles then a single ack.
        app_ref_req = 1'b1;
        @(negedge clk);
        app_ref_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("ref_busy_rdy", app_rdy, 0);
            @(negedge clk);
        end
        check("ref_exit_rdy", app_rdy, 1);
        check("ref_ack", app_ref_ack, 1);
        @(negedge clk);
        check("ref_ack_pulse", app_ref_ack, 0);

        // ZQ and refresh together: ZQ first, refresh right after.
        zq_at  = -1;
        ref_at = -1;
        app_zq_req  = 1'b1;
        app_ref_req = 1'b1;
        @(negedge clk);
        app_zq_req  = 1'b0;
        app_ref_req = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (app_zq_ack && zq_at < 0) zq_at = n;
            if (app_ref_ack && ref_at < 0) ref_at = n;
            @(negedge clk);
        end
        check("zq_ack_time", zq_at, 8);
        check("ref_after_zq_time", ref_at, 17);

        // Self-refresh held 20 cycles.
        app_sr_req = 1'b1;
        @(negedge clk);
        check("sr_entry_active", app_sr_active, 0);
        check("sr_entry_rdy", app_rdy, 0);
        @(negedge clk);
        check("sr_active_rise", app_sr_active, 1);
        repeat (18) @(negedge clk);
        check("sr_active_hold", app_sr_active, 1);
        app_sr_req = 1'b0;
        @(negedge clk);
        check("sr_exit_active", app_sr_active, 0);
        check("sr_exit_rdy", app_rdy, 1);

        // Autonomous refresh windows over 1000 idle cycles.
        do_reset();
        prev  = 1;
        start = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (prev == 1 && !app_rdy) begin
                start = n;
                falls.push_back(n);
            end
            if (prev == 0 && app_rdy) lens.push_back(n - start);
            prev = app_rdy ? 1 : 0;
        end
        check("auto_window_count", falls.size(), 3);
        if (falls.size() > 0) check("auto_first", falls[0], 256);
        for (int i = 1; i < falls.size(); i++) check("auto_period", falls[i] - falls[i-1], 256);
        for (int i = 0; i < lens.size(); i++) check("auto_busy_len", lens[i], 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
